// File: rtl/dea_decrypt_pkg.sv
// Shared DEA definitions: default widths, FSM encoding and the key-byte select
// used by both the encryptor and the decryptor.
package dea_pkg;
  localparam int DATA_W_DEF    = 8;
  localparam int KEY_BYTES_DEF = 4;
  localparam int KIDX_W        = $clog2(KEY_BYTES_DEF);

  typedef enum logic [1:0] {S_NOKEY = 2'd0, S_LOAD = 2'd1, S_RUN = 2'd2} state_t;
  typedef logic [KEY_BYTES_DEF-1:0][DATA_W_DEF-1:0] key_t;

  function automatic logic [DATA_W_DEF-1:0] key_sel(input key_t key, input logic [KIDX_W-1:0] idx);
    return key[idx];
  endfunction
endpackage

// File: rtl/dea_decrypt_if.sv
// Byte-stream bus of the DEA decryptor: key/cipher input strobes and the
// valid/ready plaintext output.
interface dea_decrypt_if import dea_pkg::*; #(parameter int DATA_W = DATA_W_DEF);
  logic              kset;
  logic              dclk;
  logic [DATA_W-1:0] din;
  logic              din_ready;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              key_loaded;
  logic              err;

  modport slave  (input kset, dclk, din, dout_ready,
                  output din_ready, dout, dout_valid, key_loaded, err);
  modport master (output kset, dclk, din, dout_ready,
                  input din_ready, dout, dout_valid, key_loaded, err);
endinterface

// File: rtl/dea_fifo.sv
// Synchronous FIFO with a registered head: the head entry is held in its own
// register so the output is flop-driven and available the cycle after a push.
module dea_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][W-1:0] mem;
  logic [PW-1:0]           wptr, rptr;
  logic [CW-1:0]           count;
  logic                    do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // A pop in the same cycle never frees room for a push into a full FIFO.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem   <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      head  <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Head follows the incoming byte when it becomes the only entry,
      // otherwise the next stored entry on a pop.
      if (do_push && (count == '0 || (count == CW'(1) && do_pop)))
        head <= wdata;
      else if (do_pop && count > CW'(1))
        head <= mem[rptr + 1'b1];
    end
  end
endmodule

// File: rtl/dea_decrypt.sv
// DEA receive side: loads a little-endian key bytewise, XORs each ciphertext
// byte with the rolling key byte and queues the plaintext in an output FIFO.
module dea_decrypt import dea_pkg::*; #(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int KEY_BYTES  = KEY_BYTES_DEF,
  parameter int FIFO_DEPTH = 4
) (
  input logic           clk,
  input logic           reset,
  dea_decrypt_if.slave  bus
);
  localparam int IW   = $clog2(KEY_BYTES);
  localparam int KC_W = $clog2(KEY_BYTES + 1);

  state_t                          state, state_nx;
  logic [KC_W-1:0]                 kcnt, kcnt_nx, widx;
  logic [KEY_BYTES-1:0][DATA_W-1:0] key;
  logic [IW-1:0]                   idx;
  logic                            key_done, accept, full, empty, err_q;

  // Key byte slot written by a kset: a kset outside S_LOAD always restarts at 0.
  always_comb begin
    widx     = (state == S_LOAD) ? kcnt : '0;
    state_nx = state;
    kcnt_nx  = kcnt;
    key_done = 1'b0;
    if (bus.kset) begin
      kcnt_nx = widx + 1'b1;
      if (widx == KC_W'(KEY_BYTES - 1)) begin
        state_nx = S_RUN;
        key_done = 1'b1;
      end else begin
        state_nx = S_LOAD;
      end
    end
  end

  assign accept = bus.dclk & ~bus.kset & (state == S_RUN) & ~full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_NOKEY;
      kcnt  <= '0;
      key   <= '0;
      idx   <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      kcnt  <= kcnt_nx;
      if (bus.kset) key[widx[IW-1:0]] <= bus.din;
      if (key_done)
        idx <= '0;
      else if (accept)
        idx <= (idx == IW'(KEY_BYTES - 1)) ? '0 : idx + 1'b1;
      if (bus.dclk && !accept) err_q <= 1'b1;
    end
  end

  dea_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .wdata (bus.din ^ key_sel(key, idx)),
    .pop   (bus.dout_ready),
    .head  (bus.dout),
    .full  (full),
    .empty (empty)
  );

  assign bus.dout_valid = ~empty;
  assign bus.key_loaded = (state == S_RUN);
  assign bus.din_ready  = (state == S_RUN) & ~full;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_dea_decrypt.sv
// Scoreboard bench for dea_decrypt: directed vectors push expected plaintext,
// a negedge monitor pops and compares on every output handshake.
module tb_dea_decrypt;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];

  dea_decrypt_if #(.DATA_W(8)) bus();
  dea_decrypt dut (.clk(clk), .reset(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.dout_valid && bus.dout_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dout_unexpected: got %h expected none", bus.dout);
      end else begin
        chk("dout", bus.dout, exp_q.pop_front());
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.kset = 1'b0; bus.dclk = 1'b0; bus.din = '0; bus.dout_ready = 1'b0;
    exp_q.delete();
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic kset(input logic [7:0] b);
    bus.din = b; bus.kset = 1'b1;
    cyc();
    bus.kset = 1'b0;
  endtask

  task automatic load_key(input logic [31:0] k);
    for (int i = 0; i < 4; i++) kset(k[8*i +: 8]);
  endtask

  // Sends a ciphertext byte; exp_push marks the expected plaintext as accepted.
  task automatic dclk(input logic [7:0] b, input bit exp_push, input logic [7:0] p);
    if (exp_push) exp_q.push_back(p);
    bus.din = b; bus.dclk = 1'b1;
    cyc();
    bus.dclk = 1'b0;
  endtask

  initial begin
    do_reset();
    rst = 1'b1;
    #1;
    chk("rst_dout_valid", 8'(bus.dout_valid), 8'd0);
    chk("rst_key_loaded", 8'(bus.key_loaded), 8'd0);
    chk("rst_err", 8'(bus.err), 8'd0);
    chk("rst_din_ready", 8'(bus.din_ready), 8'd0);
    chk("rst_dout", bus.dout, 8'h00);
    cyc();
    rst = 1'b0;

    // Basic stream, key 11 22 33 44 little-endian.
    bus.dout_ready = 1'b1;
    kset(8'h11); kset(8'h22); kset(8'h33);
    chk("t1_key_loaded_3", 8'(bus.key_loaded), 8'd0);
    kset(8'h44);
    chk("t1_key_loaded_4", 8'(bus.key_loaded), 8'd1);
    dclk(8'h50, 1, 8'h41); dclk(8'h60, 1, 8'h42); dclk(8'h70, 1, 8'h43);
    dclk(8'h00, 1, 8'h44); dclk(8'h54, 1, 8'h45);
    cyc(3);
    chk("t1_q_empty", 8'(exp_q.size()), 8'd0);
    chk("t1_err", 8'(bus.err), 8'd0);

    // Overflow with consumer stalled; rekey first so idx restarts at 0.
    bus.dout_ready = 1'b0;
    load_key(32'h44332211);
    dclk(8'h10, 1, 8'h01); dclk(8'h20, 1, 8'h02); dclk(8'h30, 1, 8'h03);
    chk("t2_din_ready_3", 8'(bus.din_ready), 8'd1);
    dclk(8'h40, 1, 8'h04);
    chk("t2_din_ready_4", 8'(bus.din_ready), 8'd0);
    chk("t2_err_before", 8'(bus.err), 8'd0);
    dclk(8'h50, 0, 8'h00);
    chk("t2_err", 8'(bus.err), 8'd1);
    chk("t2_dout_hold", bus.dout, 8'h01);
    bus.dout_ready = 1'b1;
    cyc(6);
    dclk(8'h50, 1, 8'h41);
    cyc(3);
    chk("t2_q_empty", 8'(exp_q.size()), 8'd0);

    // Cipher byte before any key.
    do_reset();
    dclk(8'h50, 0, 8'h00);
    cyc();
    chk("t3_dout_valid", 8'(bus.dout_valid), 8'd0);
    chk("t3_err", 8'(bus.err), 8'd1);

    // kset and dclk together in S_RUN: rekey wins, new key is 55 66 77 88.
    do_reset();
    load_key(32'h44332211);
    bus.din = 8'h55; bus.kset = 1'b1; bus.dclk = 1'b1;
    cyc();
    bus.kset = 1'b0; bus.dclk = 1'b0;
    chk("t4_key_loaded", 8'(bus.key_loaded), 8'd0);
    chk("t4_dout_valid", 8'(bus.dout_valid), 8'd0);
    chk("t4_err", 8'(bus.err), 8'd1);
    kset(8'h66); kset(8'h77); kset(8'h88);
    chk("t4_key_loaded_re", 8'(bus.key_loaded), 8'd1);
    bus.dout_ready = 1'b1;
    dclk(8'h05, 1, 8'h50);
    cyc(3);

    // Full FIFO with pop and dclk in the same cycle.
    do_reset();
    load_key(32'h44332211);
    dclk(8'hA0, 1, 8'hB1); dclk(8'hB0, 1, 8'h92);
    dclk(8'hC0, 1, 8'hF3); dclk(8'hD0, 1, 8'h94);
    chk("t5_err_before", 8'(bus.err), 8'd0);
    bus.dout_ready = 1'b1;
    dclk(8'hE0, 0, 8'h00);
    bus.dout_ready = 1'b0;
    chk("t5_err", 8'(bus.err), 8'd1);
    chk("t5_din_ready", 8'(bus.din_ready), 8'd1);
    chk("t5_head", bus.dout, 8'h92);
    dclk(8'h2F, 1, 8'h3E);
    chk("t5_full_again", 8'(bus.din_ready), 8'd0);
    bus.dout_ready = 1'b1;
    cyc(6);
    chk("t5_q_empty", 8'(exp_q.size()), 8'd0);

    // Async reset mid-stream with two bytes queued and err set.
    do_reset();
    dclk(8'h01, 0, 8'h00);
    load_key(32'h44332211);
    dclk(8'h50, 1, 8'h41); dclk(8'h60, 1, 8'h42);
    chk("t6_dout_valid_pre", 8'(bus.dout_valid), 8'd1);
    chk("t6_err_pre", 8'(bus.err), 8'd1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_dout_valid", 8'(bus.dout_valid), 8'd0);
    chk("t6_key_loaded", 8'(bus.key_loaded), 8'd0);
    chk("t6_err", 8'(bus.err), 8'd0);
    cyc(2);
    rst = 1'b0;
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
